arb_mux: RTL and testbench

Parametrised N-channel, W-bit selector with a valid/ready handshake on every input and on the output, and one registered output stage. It chooses one requesting channel per cycle and forwards its word with the channel index. It replaces fixed 2:1 select muxes wherever several producers share one consumer, for example write-back sources or memory request ports. Full throughput of one word per cycle.

---
 rtl/arb_mux.sv | 154 +++++++++++++++
 tb/tb_arb_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-channel, W-bit valid/ready selector with one registered output
// stage. Each cycle it picks one requesting channel and forwards that word
// with the channel index. It can move one word per cycle.
//
// Configuration macro: ARB_MUX_RR_EN
//   defined   -> round-robin arbitration. A pointer holds the last grant and
//                the search starts at the next index.
//   undefined -> fixed priority. The lowest-index valid channel wins.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [N]     per-channel word offered
//   in_data    [N*W]   channel i word at [i*W +: W]
//   in_ready   [N]     per-channel word accepted this cycle (one-hot or zero)
//   out_valid          output register holds a word
//   out_data   [W]     forwarded word
//   out_sel    [SELW]  index of the channel that supplied out_data
//   out_ready          consumer accepts the output word
module arb_mux #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;

    logic            ld;
    logic            any_valid;
    logic            accept;
    logic [SELW-1:0] grant;
    logic [W-1:0]    grant_data;

`ifdef ARB_MUX_RR_EN
    logic [SELW-1:0] ptr_q, ptr_d;
`endif

    // The search starts after ptr and wraps. It is split into two scans.
    // The first scan takes the lowest valid index above ptr. If there is
    // none, the second scan wraps to the lowest valid index overall.
    always_comb begin
        logic            found_lo;
        logic [SELW-1:0] grant_lo;
`ifdef ARB_MUX_RR_EN
        logic            found_hi;
        logic [SELW-1:0] grant_hi;
        found_hi = 1'b0;
        grant_hi = '0;
`endif
        found_lo = 1'b0;
        grant_lo = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_valid[i] && !found_lo) begin
                grant_lo = SELW'(i);
                found_lo = 1'b1;
            end
`ifdef ARB_MUX_RR_EN
            if (in_valid[i] && (i > 32'(ptr_q)) && !found_hi) begin
                grant_hi = SELW'(i);
                found_hi = 1'b1;
            end
`endif
        end
`ifdef ARB_MUX_RR_EN
        grant = found_hi ? grant_hi : grant_lo;
`else
        grant = grant_lo;
`endif
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SELW'(i) == grant) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    assign ld        = !out_valid_q || out_ready;
    assign any_valid = |in_valid;
    assign accept    = ld && any_valid;

    // in_ready is also held at zero while reset is asserted. Without that
    // term, the cleared out_valid would make ld high during reset.
    always_comb begin
        in_ready = '0;
        if (accept && rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                in_ready[i] = (SELW'(i) == grant);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (ld) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = grant_data;
                out_sel_d  = grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

`ifdef ARB_MUX_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant;
        end
    end

    // Reset to N-1 so that the first search starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SELW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed scoreboard bench for arb_mux (N=4, W=32).
// The stimulus drives inputs 1 ns after the rising edge. At the falling edge
// it checks in_ready against hand-computed constants and queues the expected
// output word. A separate monitor compares the presented output against the
// head of the queue on every falling edge where out_valid is high. The head
// is popped only when out_ready is high, so the check also confirms that the
// output holds steady under backpressure.
// Expectations follow ARB_MUX_RR_EN when it is defined.
module tb_arb_mux;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
    } item_t;

    item_t sb[$];
    int    vectors;
    int    miscompares;

    arb_mux #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the output register against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("out_data", out_data, sb[0].data);
                    check("out_sel", {30'd0, out_sel}, {30'd0, sb[0].sel});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // One cycle: drive at posedge+1, check in_ready and queue at negedge,
    // and return at the next posedge+1.
    task automatic apply(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                         input logic push, input logic [31:0] ed, input logic [1:0] es);
        item_t it;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (push) begin
            it.data = ed;
            it.sel  = es;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", {28'd0, in_ready}, 32'd0);
        end
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sel", {30'd0, out_sel}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int es[6];
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        in_valid    = '0;
        out_ready   = 1'b0;
        in_data     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        #1;
        do_reset();

        // First grant after reset goes to channel 0, then idle.
        apply(4'b1111, 1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
        apply(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_data_hold", out_data, 32'h1111_1111);
        check("idle_sel_hold", {30'd0, out_sel}, 32'd0);

        // Only channel 2 is valid.
        in_data[2*W +: W] = 32'hDEAD_BEEF;
        apply(4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2);
        apply(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0);
        in_data[2*W +: W] = 32'h3333_3333;

        // All channels valid continuously, starting from a fresh reset.
        do_reset();
`ifdef ARB_MUX_RR_EN
        es = '{0, 1, 2, 3, 0, 1};
`else
        es = '{0, 0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 6; k++) begin
            logic [3:0]  r;
            logic [31:0] d;
            r = 4'b0001 << es[k];
            d = in_data[es[k]*W +: W];
            apply(4'b1111, 1'b1, r, 1'b1, d, 2'(es[k]));
        end
        apply(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0);

        // Backpressure: channel 3 word stalls for 5 cycles while ch1 waits.
        apply(4'b1000, 1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
        repeat (5) apply(4'b0010, 1'b0, 4'b0000, 1'b0, '0, '0);
        apply(4'b0010, 1'b1, 4'b0010, 1'b1, 32'h2222_2222, 2'd1);
        apply(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0);

        // Asynchronous reset while channel 3's word is held.
        apply(4'b1000, 1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_out_sel", {30'd0, out_sel}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out_data", out_data, 32'd0);
        check("async_out_sel", {30'd0, out_sel}, 32'd0);
        check("async_in_ready", {28'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'b1111, 1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
        apply(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0);
        apply(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0);

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
